// File: rtl/leaf_bit_decider.sv
// Leaf hard-decision stage for a successive-cancellation polar decoder.
// u_hat is registered one cycle after each accepted leaf LLR, and msg_out collects the information bits.
// There is no stall output: one LLR is consumed per llr_valid cycle in RUN, and llr_valid is ignored outside RUN.
module leaf_bit_decider #(
   parameter int LLR_W = 19,
   parameter int N_MAX = 512,
   parameter int K_MAX = 140,
   parameter int IDX_W = 9
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           start,
   input  logic [$clog2(N_MAX+1)-1:0]     n_len,
   input  logic [$clog2(K_MAX+1)-1:0]     k_len,
   input  logic [LLR_W-1:0]               llr_in,
   input  logic                           llr_valid,
   input  logic                           frozen,
   output logic                           u_hat,
   output logic                           u_valid,
   output logic [IDX_W-1:0]               bit_idx,
   output logic [K_MAX-1:0]               msg_out,
   output logic [$clog2(K_MAX+1)-1:0]     info_cnt,
   output logic                           busy,
   output logic                           done,
   output logic                           err
);

   localparam int NL_W = $clog2(N_MAX + 1);
   localparam int KC_W = $clog2(K_MAX + 1);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_RUN    = 2'd1,
      S_FINISH = 2'd2
   } state_t;

   state_t            state_q, state_d;
   logic [NL_W-1:0]   n_q, n_d;
   logic [KC_W-1:0]   k_q, k_d;
   logic              u_hat_q, u_hat_d;
   logic              u_valid_q, u_valid_d;
   logic [IDX_W-1:0]  bit_idx_q, bit_idx_d;
   logic [K_MAX-1:0]  msg_q, msg_d;
   logic [KC_W-1:0]   info_cnt_q, info_cnt_d;
   logic              err_q, err_d;
   logic              u_dec;
   logic              last_idx;

   // Hard decision on the leaf LLR: frozen indices are forced to 0 and a negative LLR decodes to 1.
   always_comb begin
      u_dec    = frozen ? 1'b0 : llr_in[LLR_W-1];
      last_idx = (NL_W'(bit_idx_q) == (n_q - NL_W'(1)));
   end

   // Next-state logic: codeword sequencing, info-bit packing, and overflow/underflow tracking.
   always_comb begin
      state_d    = state_q;
      n_d        = n_q;
      k_d        = k_q;
      u_hat_d    = u_hat_q;
      u_valid_d  = 1'b0;
      bit_idx_d  = bit_idx_q;
      msg_d      = msg_q;
      info_cnt_d = info_cnt_q;
      err_d      = err_q;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               n_d        = n_len;
               k_d        = k_len;
               bit_idx_d  = '0;
               info_cnt_d = '0;
               msg_d      = '0;
               err_d      = 1'b0;
               state_d    = S_RUN;
            end
         end

         S_RUN: begin
            if (llr_valid) begin
               u_hat_d   = u_dec;
               u_valid_d = 1'b1;
               if (!frozen) begin
                  if (info_cnt_q < k_q) begin
                     // Write the decision into message slot info_cnt.
                     for (int j = 0; j < K_MAX; j++) begin
                        if (32'(info_cnt_q) == j) begin
                           msg_d[j] = u_dec;
                        end
                     end
                     info_cnt_d = info_cnt_q + KC_W'(1);
                  end else begin
                     // More unfrozen indices than K: drop the bit and flag it.
                     err_d = 1'b1;
                  end
               end
               if (last_idx) begin
                  bit_idx_d = '0;
                  state_d   = S_FINISH;
               end else begin
                  bit_idx_d = bit_idx_q + IDX_W'(1);
               end
            end
         end

         S_FINISH: begin
            // Fewer unfrozen indices than K means the message is incomplete.
            if (info_cnt_q != k_q) begin
               err_d = 1'b1;
            end
            state_d = S_IDLE;
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State register. A synchronous reset overrides everything, including a codeword in flight.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_IDLE;
         n_q        <= '0;
         k_q        <= '0;
         u_hat_q    <= 1'b0;
         u_valid_q  <= 1'b0;
         bit_idx_q  <= '0;
         msg_q      <= '0;
         info_cnt_q <= '0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         n_q        <= n_d;
         k_q        <= k_d;
         u_hat_q    <= u_hat_d;
         u_valid_q  <= u_valid_d;
         bit_idx_q  <= bit_idx_d;
         msg_q      <= msg_d;
         info_cnt_q <= info_cnt_d;
         err_q      <= err_d;
      end
   end

   // Output mapping. busy and done are decoded directly from the state register.
   always_comb begin
      u_hat    = u_hat_q;
      u_valid  = u_valid_q;
      bit_idx  = bit_idx_q;
      msg_out  = msg_q;
      info_cnt = info_cnt_q;
      err      = err_q;
      busy     = (state_q == S_RUN);
      done     = (state_q == S_FINISH);
   end

endmodule

// File: tb/tb_leaf_bit_decider.sv
// Self-checking bench for leaf_bit_decider: a scoreboard of expected decisions plus directed codeword runs.
module tb_leaf_bit_decider;

   logic          clk;
   logic          rst;
   logic          start;
   logic [9:0]    n_len;
   logic [7:0]    k_len;
   logic [18:0]   llr_in;
   logic          llr_valid;
   logic          frozen;
   logic          u_hat;
   logic          u_valid;
   logic [8:0]    bit_idx;
   logic [139:0]  msg_out;
   logic [7:0]    info_cnt;
   logic          busy;
   logic          done;
   logic          err;

   leaf_bit_decider #(.LLR_W(19), .N_MAX(512), .K_MAX(140), .IDX_W(9)) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .n_len     (n_len),
      .k_len     (k_len),
      .llr_in    (llr_in),
      .llr_valid (llr_valid),
      .frozen    (frozen),
      .u_hat     (u_hat),
      .u_valid   (u_valid),
      .bit_idx   (bit_idx),
      .msg_out   (msg_out),
      .info_cnt  (info_cnt),
      .busy      (busy),
      .done      (done),
      .err       (err)
   );

   typedef struct {
      logic u;
      int   cyc;
   } exp_t;

   typedef struct {
      logic [18:0] llr;
      logic        fz;
      logic        exp_u;
   } vec_t;

   exp_t  sb[$];
   int    n_chk = 0;
   int    n_pass = 0;
   int    cyc = 0;
   int    done_cnt = 0;
   int    done_cyc = -1;
   int    last_vld_cyc = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string nm, input logic [159:0] act, input logic [159:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
   endtask

   // Monitor: every u_valid pops the scoreboard and is checked for both value and 1-cycle latency.
   always @(negedge clk) begin
      if (u_valid) begin
         if (sb.size() == 0) begin
            n_chk++;
            $display("FAIL spurious_u_valid: got u_valid=1 at cycle %0d expected none", cyc);
         end else begin
            exp_t e;
            e = sb.pop_front();
            check("u_hat", 160'(u_hat), 160'(e.u));
            check("u_latency", 160'(cyc), 160'(e.cyc));
         end
      end
      if (done) begin
         done_cnt++;
         done_cyc = cyc;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      repeat (n) tick();
   endtask

   task automatic do_start(input logic [9:0] n, input logic [7:0] k);
      n_len = n;
      k_len = k;
      start = 1'b1;
      tick();
      start = 1'b0;
      done_cnt = 0;
      done_cyc = -1;
   endtask

   function automatic logic dec(input logic [18:0] llr, input logic fz);
      return fz ? 1'b0 : llr[18];
   endfunction

   // Present one leaf LLR for a single cycle and queue the decision expected one cycle later.
   task automatic drive_idx(input logic [18:0] llr, input logic fz, input logic exp_u, input logic sv);
      exp_t e;
      llr_in    = llr;
      frozen    = fz;
      llr_valid = 1'b1;
      start     = sv;
      e.u       = exp_u;
      e.cyc     = cyc + 1;
      sb.push_back(e);
      last_vld_cyc = cyc;
      tick();
      llr_valid = 1'b0;
      start     = 1'b0;
   endtask

   function automatic logic [18:0] rnd_llr();
      logic [31:0] r;
      r = $urandom;
      return r[18:0];
   endfunction

   task automatic check_end(input string nm);
      check({nm, "_done_cnt"}, 160'(done_cnt), 160'(1));
      check({nm, "_done_cyc"}, 160'(done_cyc), 160'(last_vld_cyc + 1));
      check({nm, "_sb_empty"}, 160'(sb.size()), 160'(0));
      check({nm, "_busy"}, 160'(busy), 160'(0));
   endtask

   initial begin
      vec_t        tab[8];
      logic [18:0] l;
      logic [139:0] exp_msg;

      // Leaf vectors for indices 120..127 of the N=128, K=4 codeword.
      tab[0] = '{llr: 19'h7FFFF, fz: 1'b1, exp_u: 1'b0};
      tab[1] = '{llr: 19'h00003, fz: 1'b1, exp_u: 1'b0};
      tab[2] = '{llr: 19'h40000, fz: 1'b1, exp_u: 1'b0};
      tab[3] = '{llr: 19'h3FFFF, fz: 1'b1, exp_u: 1'b0};
      tab[4] = '{llr: 19'h7FFFB, fz: 1'b0, exp_u: 1'b1};  // -5
      tab[5] = '{llr: 19'h00007, fz: 1'b0, exp_u: 1'b0};  // 7
      tab[6] = '{llr: 19'h00000, fz: 1'b0, exp_u: 1'b0};  // 0
      tab[7] = '{llr: 19'h40000, fz: 1'b0, exp_u: 1'b1};  // -262144

      rst = 1'b1; start = 1'b0; n_len = '0; k_len = '0;
      llr_in = '0; llr_valid = 1'b0; frozen = 1'b0;
      idle(3);
      check("rst_u_hat", 160'(u_hat), 160'(0));
      check("rst_u_valid", 160'(u_valid), 160'(0));
      check("rst_bit_idx", 160'(bit_idx), 160'(0));
      check("rst_msg", 160'(msg_out), 160'(0));
      check("rst_info_cnt", 160'(info_cnt), 160'(0));
      check("rst_busy", 160'(busy), 160'(0));
      check("rst_done", 160'(done), 160'(0));
      check("rst_err", 160'(err), 160'(0));
      rst = 1'b0;
      idle(2);

      // 1: all frozen, K=0
      do_start(10'd128, 8'd0);
      check("t1_busy", 160'(busy), 160'(1));
      for (int i = 0; i < 128; i++) begin
         l = rnd_llr();
         drive_idx(l, 1'b1, 1'b0, 1'b0);
      end
      idle(3);
      check_end("t1");
      check("t1_info_cnt", 160'(info_cnt), 160'(0));
      check("t1_err", 160'(err), 160'(0));
      check("t1_msg", 160'(msg_out), 160'(0));

      // 2: K=4, info indices 124..127 taken from the table
      do_start(10'd128, 8'd4);
      for (int i = 0; i < 120; i++) begin
         l = rnd_llr();
         drive_idx(l, 1'b1, 1'b0, 1'b0);
      end
      for (int t = 0; t < 8; t++) begin
         drive_idx(tab[t].llr, tab[t].fz, tab[t].exp_u, 1'b0);
      end
      idle(3);
      check_end("t2");
      check("t2_msg", 160'(msg_out), 160'(4'b1001));
      check("t2_info_cnt", 160'(info_cnt), 160'(4));
      check("t2_err", 160'(err), 160'(0));

      // 3: K=2 with three unfrozen indices -> overflow
      do_start(10'd256, 8'd2);
      for (int i = 0; i < 256; i++) begin
         if (i == 10)      drive_idx(19'h7FFFF, 1'b0, 1'b1, 1'b0);
         else if (i == 20) drive_idx(19'h00005, 1'b0, 1'b0, 1'b0);
         else if (i == 30) drive_idx(19'h7FFF9, 1'b0, 1'b1, 1'b0);
         else begin
            l = rnd_llr();
            drive_idx(l, 1'b1, 1'b0, 1'b0);
         end
      end
      check("t3_err_finish", 160'(err), 160'(1));
      idle(6);
      check_end("t3");
      check("t3_msg", 160'(msg_out), 160'(2'b01));
      check("t3_info_cnt", 160'(info_cnt), 160'(2));
      check("t3_err_idle", 160'(err), 160'(1));

      // 3b: K=3 with one unfrozen index -> underflow flagged on FINISH
      do_start(10'd128, 8'd3);
      check("t3b_err_cleared", 160'(err), 160'(0));
      for (int i = 0; i < 128; i++) begin
         if (i == 5) drive_idx(19'h7FFF7, 1'b0, 1'b1, 1'b0);
         else begin
            l = rnd_llr();
            drive_idx(l, 1'b1, 1'b0, 1'b0);
         end
      end
      check("t3b_done_now", 160'(done), 160'(1));
      check("t3b_err_before", 160'(err), 160'(0));
      tick();
      check("t3b_err_after", 160'(err), 160'(1));
      idle(2);
      check_end("t3b");
      check("t3b_msg", 160'(msg_out), 160'(1));

      // 4: N=512, K=140, gapped valids, ignored start at index 300
      do_start(10'd512, 8'd140);
      check("t4_err_cleared", 160'(err), 160'(0));
      exp_msg = '0;
      for (int i = 0; i < 512; i++) begin
         l = rnd_llr();
         if (i == 300) begin
            check("t4_bit_idx_300", 160'(bit_idx), 160'(300));
            n_len = 10'd128;
            k_len = 8'd1;
         end
         if (i >= 372) begin
            exp_msg[i-372] = l[18];
            drive_idx(l, 1'b0, dec(l, 1'b0), 1'b0);
         end else begin
            drive_idx(l, 1'b1, 1'b0, (i == 300));
         end
         if (i == 300) begin
            check("t4_bit_idx_301", 160'(bit_idx), 160'(301));
            check("t4_busy_300", 160'(busy), 160'(1));
         end
         idle(2);
      end
      idle(2);
      check_end("t4");
      check("t4_msg", 160'(msg_out), 160'(exp_msg));
      check("t4_info_cnt", 160'(info_cnt), 160'(140));
      check("t4_err", 160'(err), 160'(0));

      // 5: reset mid-codeword, then a clean N=128, K=1 codeword
      do_start(10'd128, 8'd5);
      for (int i = 0; i < 60; i++) begin
         if (i < 5) drive_idx(19'h7FFF0, 1'b0, 1'b1, 1'b0);
         else begin
            l = rnd_llr();
            drive_idx(l, 1'b1, 1'b0, 1'b0);
         end
      end
      check("t5_msg_pre", 160'(msg_out), 160'(5'h1F));
      rst = 1'b1; llr_valid = 1'b1; frozen = 1'b0; llr_in = 19'h7FFF0;
      tick();
      rst = 1'b0; llr_valid = 1'b0;
      check("t5_u_valid", 160'(u_valid), 160'(0));
      check("t5_u_hat", 160'(u_hat), 160'(0));
      check("t5_bit_idx", 160'(bit_idx), 160'(0));
      check("t5_msg", 160'(msg_out), 160'(0));
      check("t5_info_cnt", 160'(info_cnt), 160'(0));
      check("t5_busy", 160'(busy), 160'(0));
      check("t5_done", 160'(done), 160'(0));
      check("t5_err", 160'(err), 160'(0));
      idle(2);
      do_start(10'd128, 8'd1);
      for (int i = 0; i < 128; i++) begin
         if (i == 127) drive_idx(19'h7FFFD, 1'b0, 1'b1, 1'b0);
         else begin
            l = rnd_llr();
            drive_idx(l, 1'b1, 1'b0, 1'b0);
         end
      end
      idle(3);
      check_end("t5b");
      check("t5b_msg", 160'(msg_out), 160'(1));
      check("t5b_info_cnt", 160'(info_cnt), 160'(1));
      check("t5b_err", 160'(err), 160'(0));

      // 6: llr_valid in IDLE is ignored
      for (int i = 0; i < 3; i++) begin
         llr_valid = 1'b1; frozen = 1'b0; llr_in = 19'h7FFF0;
         tick();
         llr_valid = 1'b0;
         tick();
      end
      idle(2);
      check("t6_bit_idx", 160'(bit_idx), 160'(0));
      check("t6_msg", 160'(msg_out), 160'(1));
      check("t6_info_cnt", 160'(info_cnt), 160'(1));
      check("t6_busy", 160'(busy), 160'(0));
      check("t6_sb_empty", 160'(sb.size()), 160'(0));

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
